memory_stage: RTL and testbench

- Pipeline stage directly downstream of Execute in the 5-stage RV32I core.
- Registers Execute outputs (ALU result, store data, rd, pc+4, memory control) and performs load/store through a valid/ready data-memory port.
- Formats load data (byte/half/word, sign/zero extend) and generates store byte strobes.
- Stalls the pipeline while a memory access is outstanding; m_alu_result feeds Execute's forwarding mux.

---
 rtl/memory_stage.sv | 158 +++++++++++++++
 tb/tb_memory_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: RV32I memory stage with valid/ready data port, load formatting and store strobes (option: MEM_MISALIGN_TRAP_EN)
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           e_alu_result,
    input  logic [31:0]           e_write_data,
    input  logic [4:0]            e_rd,
    input  logic [31:0]           e_pc_plus_4,
    input  logic                  e_mem_read,
    input  logic                  e_mem_write,
    input  logic [1:0]            e_mem_size,
    input  logic                  e_mem_unsigned,
    output logic [31:0]           m_alu_result,
    output logic [4:0]            m_rd,
    output logic [31:0]           m_pc_plus_4,
    output logic [31:0]           m_read_data,
    output logic                  m_mem_read,
    output logic                  m_stall,
    output logic                  m_bus_error,
    output logic                  m_misaligned,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_req_write,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic                  dmem_resp_valid,
    input  logic [31:0]           dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    localparam logic [31:0] TO = TIMEOUT_CYCLES;
    state_t      state_q, state_d;
    logic [31:0] alu_q, alu_d, wdata_q, wdata_d, pc4_q, pc4_d, rdata_q, rdata_d, cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  size_q, size_d;
    logic        mrd_q, mrd_d, mwr_q, mwr_d, uns_q, uns_d, berr_q, berr_d, mis_q, mis_d;
    logic        e_mis;
    logic [1:0]  off;
    logic [31:0] addr_al, load_fmt;
    logic [7:0]  lb;
    logic [15:0] lh;

`ifdef MEM_MISALIGN_TRAP_EN
    assign e_mis   = (e_mem_read | e_mem_write) &&
                     ((e_mem_size == 2'b01 && e_alu_result[0]) || (e_mem_size[1] && e_alu_result[1:0] != 2'b00));
    assign addr_al = alu_q;
`else
    assign e_mis   = 1'b0;
    assign addr_al = {alu_q[31:2], size_q[1] ? 2'b00 : {alu_q[1], size_q == 2'b01 ? 1'b0 : alu_q[0]}};
`endif

    assign off            = alu_q[1:0];
    assign m_stall        = (state_q == REQ) || (state_q == WAIT);
    assign dmem_req_valid = (state_q == REQ);
    assign dmem_req_write = mwr_q;
    assign dmem_addr      = addr_al[ADDR_WIDTH-1:0];
    assign dmem_wdata     = size_q == 2'b00 ? {4{wdata_q[7:0]}} : size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign dmem_wstrb     = !mwr_q ? 4'b0000 : size_q == 2'b00 ? 4'b0001 << off :
                            size_q == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    assign m_alu_result   = alu_q;
    assign m_rd           = rd_q;
    assign m_pc_plus_4    = pc4_q;
    assign m_read_data    = rdata_q;
    assign m_mem_read     = mrd_q;
    assign m_bus_error    = berr_q;
    assign m_misaligned   = mis_q;

    // Select the addressed lane of the response word and sign/zero extend it
    always_comb begin
        lb       = dmem_rdata[{off, 3'b000} +: 8];
        lh       = dmem_rdata[{off[1], 4'b0000} +: 16];
        load_fmt = size_q == 2'b00 ? {{24{~uns_q & lb[7]}}, lb} :
                   size_q == 2'b01 ? {{16{~uns_q & lh[15]}}, lh} : dmem_rdata;
    end

    // Next state: load the stage register when not stalled, else advance the access
    always_comb begin
        state_d = state_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        pc4_d   = pc4_q;
        rd_d    = rd_q;
        size_d  = size_q;
        mrd_d   = mrd_q;
        mwr_d   = mwr_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        berr_d  = berr_q;
        mis_d   = mis_q;
        if (!m_stall) begin
            alu_d   = e_alu_result;
            wdata_d = e_write_data;
            pc4_d   = e_pc_plus_4;
            rd_d    = e_rd;
            size_d  = e_mem_size;
            mrd_d   = e_mem_read;
            mwr_d   = e_mem_write;
            uns_d   = e_mem_unsigned;
            rdata_d = '0;
            cnt_d   = '0;
            berr_d  = 1'b0;
            mis_d   = e_mis;
            state_d = ((e_mem_read | e_mem_write) && !e_mis) ? REQ : IDLE;
        end else if (state_q == REQ) begin
            if (dmem_req_ready) begin
                state_d = mwr_q ? DONE : WAIT;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 32'd1;
            if (dmem_resp_valid) begin
                rdata_d = load_fmt;
                state_d = DONE;
            end else if (TO != 32'd0 && cnt_d == TO) begin
                berr_d  = 1'b1;
                rdata_d = '0;
                state_d = DONE;
            end
        end
    end

    // State and stage registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            alu_q   <= '0;
            wdata_q <= '0;
            pc4_q   <= '0;
            rd_q    <= '0;
            size_q  <= '0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            pc4_q   <= pc4_d;
            rd_q    <= rd_d;
            size_q  <= size_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            berr_q  <= berr_d;
            mis_q   <= mis_d;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized scoreboard bench for memory_stage with a behavioural memory and reference model
module tb_memory_stage;
    localparam int TO = 4;
    logic        clk = 0, reset = 0;
    logic [31:0] e_alu_result = 0, e_write_data = 0, e_pc_plus_4 = 0;
    logic [4:0]  e_rd = 0;
    logic        e_mem_read = 0, e_mem_write = 0, e_mem_unsigned = 0;
    logic [1:0]  e_mem_size = 0;
    logic [31:0] m_alu_result, m_pc_plus_4, m_read_data, dmem_addr, dmem_wdata;
    logic [4:0]  m_rd;
    logic        m_mem_read, m_stall, m_bus_error, m_misaligned, dmem_req_valid, dmem_req_write;
    logic [3:0]  dmem_wstrb;
    logic        dmem_req_ready = 0, dmem_resp_valid = 0;
    logic [31:0] dmem_rdata = 0;

    memory_stage #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .e_alu_result(e_alu_result), .e_write_data(e_write_data), .e_rd(e_rd), .e_pc_plus_4(e_pc_plus_4),
        .e_mem_read(e_mem_read), .e_mem_write(e_mem_write), .e_mem_size(e_mem_size), .e_mem_unsigned(e_mem_unsigned),
        .m_alu_result(m_alu_result), .m_rd(m_rd), .m_pc_plus_4(m_pc_plus_4), .m_read_data(m_read_data),
        .m_mem_read(m_mem_read), .m_stall(m_stall), .m_bus_error(m_bus_error), .m_misaligned(m_misaligned),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_write(dmem_req_write),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, pc4, rdata;
        logic [4:0]  rd;
        logic        mrd, chk_rdata, berr, mis;
        int          stall;
    } exp_t;
    typedef struct {
        logic [31:0] addr, wdata, mword;
        logic [3:0]  wstrb;
        logic        wr;
        int          rdy, rsp;
    } plan_t;

    exp_t  expq[$];
    plan_t planq[$];
    int    nchk = 0, nerr = 0;
    bit    mem_auto = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] w, input int sz, input int off, input bit uns);
        int unsigned b, h;
        if (sz == 0) begin
            b = (w >> (8 * off)) % 256;
            return (!uns && b >= 128) ? b + 32'hFFFF_FF00 : b;
        end
        if (sz == 1) begin
            h = (w >> (16 * (off / 2))) % 65536;
            return (!uns && h >= 32768) ? h + 32'hFFFF_0000 : h;
        end
        return w;
    endfunction

    task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input bit rdf, input bit wrf,
                         input int sz, input bit uns, input int rdy, input int rsp, input logic [31:0] mword);
        exp_t  e;
        plan_t p;
        int    g = 0, off;
        bit    mem, mis, go;
        while (m_stall && g < 200) begin
            cyc();
            g++;
        end
        if (g >= 200) begin
            nchk++;
            nerr++;
            $display("FAIL stall_bound: stall never released within 200 cycles");
            finish_run();
        end
        e_alu_result = alu; e_write_data = wd; e_mem_read = rdf; e_mem_write = wrf;
        e_mem_size = 2'(sz); e_mem_unsigned = uns; e_rd = 5'($urandom); e_pc_plus_4 = $urandom;
        mem = rdf | wrf;
        off = int'(alu % 4);
`ifdef MEM_MISALIGN_TRAP_EN
        mis = mem && ((sz == 1 && off % 2 == 1) || (sz >= 2 && off != 0));
`else
        mis = 0;
`endif
        go = mem && !mis;
        e.alu = alu; e.pc4 = e_pc_plus_4; e.rd = e_rd; e.mrd = rdf; e.mis = mis;
        e.berr = go && rdf && rsp >= TO;
        e.chk_rdata = rdf;
        e.rdata = (!go || e.berr) ? 32'h0 : load_val(mword, sz, off, uns);
        e.stall = !go ? 0 : (rdy + 1 + (wrf ? 0 : (rsp < TO ? rsp + 1 : TO)));
        if (go) begin
            p.addr  = sz == 1 ? alu - (alu % 2) : sz >= 2 ? alu - (alu % 4) : alu;
            p.wr    = wrf;
            p.wdata = sz == 0 ? (wd % 256) * 32'h0101_0101 : sz == 1 ? (wd % 65536) * 32'h0001_0001 : wd;
            p.wstrb = !wrf ? 4'd0 : sz == 0 ? 4'(1 << off) : sz == 1 ? 4'(3 << (2 * (off / 2))) : 4'd15;
            p.rdy = rdy; p.rsp = rsp; p.mword = mword;
            planq.push_back(p);
        end
        expq.push_back(e);
        cyc();
    endtask

    // Monitor: count stall cycles and check each op once the stage releases it
    initial begin
        int   stall_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                if (m_stall) stall_cnt++;
                else begin
                    e = expq.pop_front();
                    chk("m_alu_result", m_alu_result, e.alu);
                    chk("m_rd", 32'(m_rd), 32'(e.rd));
                    chk("m_pc_plus_4", m_pc_plus_4, e.pc4);
                    chk("m_mem_read", 32'(m_mem_read), 32'(e.mrd));
                    chk("m_bus_error", 32'(m_bus_error), 32'(e.berr));
                    chk("m_misaligned", 32'(m_misaligned), 32'(e.mis));
                    chk("stall_cycles", stall_cnt, e.stall);
                    if (e.chk_rdata) chk("m_read_data", m_read_data, e.rdata);
                    stall_cnt = 0;
                end
            end
        end
    end

    // Behavioural data memory: delayed ready, delayed or missing response, stray responses when idle
    initial begin
        plan_t p;
        forever begin
            @(negedge clk);
            #2;
            while (mem_auto && dmem_req_valid) begin
                if (planq.size() == 0) begin
                    chk("unexpected_request", 32'(dmem_req_valid), 32'd0);
                    break;
                end
                p = planq.pop_front();
                for (int i = 0; i <= p.rdy; i++) begin
                    chk("req_valid", 32'(dmem_req_valid), 32'd1);
                    chk("dmem_addr", dmem_addr, p.addr);
                    chk("req_write", 32'(dmem_req_write), 32'(p.wr));
                    chk("dmem_wstrb", 32'(dmem_wstrb), 32'(p.wstrb));
                    if (p.wr) chk("dmem_wdata", dmem_wdata, p.wdata);
                    dmem_req_ready = (i == p.rdy);
                    @(negedge clk);
                    #2;
                end
                dmem_req_ready = 0;
                if (!p.wr)
                    for (int k = 1; k <= TO; k++) begin
                        dmem_resp_valid = (k == p.rsp + 1);
                        dmem_rdata = (k == p.rsp + 1) ? p.mword : $urandom;
                        @(negedge clk);
                        #2;
                        dmem_resp_valid = 0;
                        if (k == p.rsp + 1) break;
                    end
            end
            if (mem_auto) begin
                dmem_resp_valid = ($urandom % 3 == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    initial begin
        int g;
        repeat (3) cyc();
        chk("rst_alu", m_alu_result, 32'h0);
        chk("rst_rd", 32'(m_rd), 32'h0);
        chk("rst_pc4", m_pc_plus_4, 32'h0);
        chk("rst_rdata", m_read_data, 32'h0);
        chk("rst_flags", {27'h0, m_stall, dmem_req_valid, m_bus_error, m_misaligned, m_mem_read}, 32'h0);
        reset = 1;
        mem_auto = 1;
        cyc();
        issue(32'h103, 0, 1, 0, 0, 0, 0, 0, 32'h80FF_FF12);
        issue(32'h103, 0, 1, 0, 0, 1, 0, 0, 32'h80FF_FF12);
        issue(32'h202, 32'h0000_BEEF, 0, 1, 1, 0, 0, 0, 0);
        issue(32'h300, 0, 1, 0, 2, 0, 3, 3, 32'hCAFE_F00D);
        issue(32'h304, 0, 1, 0, 2, 0, 0, 9, 32'h1111_2222);
        issue(32'h102, 0, 1, 0, 2, 0, 0, 0, 32'h5A5A_A5A5);
        issue(32'h400, 32'h1, 0, 0, 2, 0, 0, 0, 0);
        for (int n = 0; n < 80; n++) begin
            int kind = $urandom % 4;
            issue($urandom, $urandom, kind == 1 || kind == 3, kind == 2, $urandom % 4, 1'($urandom),
                  $urandom % 3, $urandom % 6, $urandom);
        end
        issue(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        g = 0;
        while (expq.size() > 0 && g < 200) begin
            cyc();
            g++;
        end
        chk("drain", expq.size(), 0);
        mem_auto = 0;
        dmem_req_ready = 0;
        dmem_resp_valid = 0;
        cyc();
        e_alu_result = 32'h40; e_mem_read = 1; e_mem_write = 0; e_mem_size = 2; e_rd = 5'd7; e_pc_plus_4 = 32'h44;
        cyc();
        e_mem_read = 0;
        chk("rst_t_req", 32'(dmem_req_valid), 32'd1);
        dmem_req_ready = 1;
        cyc();
        dmem_req_ready = 0;
        chk("rst_t_wait_stall", 32'(m_stall), 32'd1);
        chk("rst_t_wait_noreq", 32'(dmem_req_valid), 32'd0);
        reset = 0;
        #1;
        chk("rst_async_req", 32'(dmem_req_valid), 32'd0);
        chk("rst_async_stall", 32'(m_stall), 32'd0);
        chk("rst_async_alu", m_alu_result, 32'h0);
        chk("rst_async_rd_pc", {m_rd, m_pc_plus_4[26:0]}, 32'h0);
        chk("rst_async_mrd", 32'(m_mem_read), 32'd0);
        cyc();
        reset = 1;
        dmem_resp_valid = 1;
        dmem_rdata = 32'hDEAD_BEEF;
        cyc();
        dmem_resp_valid = 0;
        chk("late_resp_rdata", m_read_data, 32'h0);
        chk("late_resp_stall", 32'(m_stall), 32'd0);
        e_alu_result = 32'h80; e_mem_read = 1; e_mem_size = 2; e_mem_unsigned = 0;
        dmem_req_ready = 1;
        cyc();
        e_mem_read = 0;
        cyc();
        dmem_req_ready = 0;
        dmem_resp_valid = 1;
        dmem_rdata = 32'h1234_5678;
        cyc();
        dmem_resp_valid = 0;
        chk("post_rst_rdata", m_read_data, 32'h1234_5678);
        chk("post_rst_stall", 32'(m_stall), 32'd0);
        chk("post_rst_berr", 32'(m_bus_error), 32'd0);
        finish_run();
    end
endmodule
